// File: rtl/gf2671_pkg.sv
// Shared constants and types for GF(2671) arithmetic blocks.
package gf2671_pkg;

    localparam int unsigned W       = 12;
    localparam int unsigned Q       = 2671;
    localparam int unsigned MU      = 6281;
    localparam int unsigned EXP_MSB = 11;
    localparam int unsigned NUM_MUL = 6;
    localparam int unsigned LATENCY = 18;
    localparam int unsigned IDX_W   = 4;

    // Fermat exponent Q-2, scanned MSB to LSB
    localparam logic [W-1:0] EXP = 12'b1010_0110_1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/modmul_2671.sv
// Combinational a*b mod 2671: 12x12 product, Barrett estimate, then up to two corrections.
module modmul_2671
    import gf2671_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r
);

    logic [23:0] prod;
    logic [24:0] t_mu;
    logic [12:0] t;
    logic [24:0] tq;
    logic [24:0] r0;
    logic [24:0] r1;
    logic [24:0] r2;

    // Quotient estimate undershoots by at most two, hence two conditional subtracts
    always_comb begin
        prod = 24'(a) * 24'(b);
        t_mu = 25'(prod >> 12) * 25'(MU);
        t    = 13'(t_mu >> 12);
        tq   = 25'(t) * 25'(Q);
        r0   = 25'(prod) - tq;
        r1   = (r0 >= 25'(Q)) ? r0 - 25'(Q) : r0;
        r2   = (r1 >= 25'(Q)) ? r1 - 25'(Q) : r1;
        r    = W'(r2);
    end

endmodule

// File: rtl/modinv_2671.sv
// Sequential GF(2671) inverter: a^(Q-2) by left-to-right square-and-multiply, one operand at a time.
module modinv_2671
    import gf2671_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_inv,
    output logic         out_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_nxt;
    logic [W-1:0]     base;
    logic [W-1:0]     base_nxt;
    logic             in_ready_nxt;
    logic             out_valid_nxt;
    logic [W-1:0]     out_inv_nxt;
    logic             out_zero_nxt;
    logic [W-1:0]     a_red;
    logic [W-1:0]     mm_b;
    logic [W-1:0]     mm_r;

    // 4095 < 2Q, so a single subtract fully reduces the operand
    assign a_red = (in_a >= W'(Q)) ? in_a - W'(Q) : in_a;
    assign mm_b  = (state == MUL) ? base : acc;

    modmul_2671 u_modmul (
        .a (acc),
        .b (mm_b),
        .r (mm_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= IDX_W'(EXP_MSB - 1);
            acc       <= '0;
            base      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_inv   <= '0;
            out_zero  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            acc       <= acc_nxt;
            base      <= base_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_inv   <= out_inv_nxt;
            out_zero  <= out_zero_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        acc_nxt       = acc;
        base_nxt      = base;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        out_inv_nxt   = out_inv;
        out_zero_nxt  = out_zero;
        case (state)
            IDLE: begin
                in_ready_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    base_nxt     = a_red;
                    acc_nxt      = a_red;
                    idx_nxt      = IDX_W'(EXP_MSB - 1);
                    in_ready_nxt = 1'b0;
                    state_nxt    = SQR;
                end
            end
            SQR: begin
                acc_nxt = mm_r;
                if (EXP[idx]) begin
                    state_nxt = MUL;
                end else if (idx == '0) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - IDX_W'(1);
                end
            end
            MUL: begin
                acc_nxt = mm_r;
                if (idx == '0) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx - IDX_W'(1);
                    state_nxt = SQR;
                end
            end
            DONE: begin
                // Result is registered one cycle after entry and then held until taken
                out_valid_nxt = 1'b1;
                out_inv_nxt   = acc;
                out_zero_nxt  = (base == '0);
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_modinv_2671.sv
// Self-checking bench for modinv_2671 with a cycle-level reference model and standalone modmul sweep.
module tb_modinv_2671;
    import gf2671_pkg::*;

    localparam int QI = 2671;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_a = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_inv;
    logic        out_zero;
    logic [11:0] mm_a = '0;
    logic [11:0] mm_b = '0;
    logic [11:0] mm_r;

    int n_pass = 0;
    int n_total = 0;

    // model: 0 = idle/accepting, 1 = computing, 2 = result presented
    int m_state = 0;
    int m_cnt = 0;
    int m_inv = 0;
    int m_zero = 0;

    modinv_2671 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .out_zero  (out_zero)
    );

    modmul_2671 u_mm (
        .a (mm_a),
        .b (mm_b),
        .r (mm_r)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Modular inverse by the extended Euclidean algorithm; 0 for non-invertible
    function automatic int inv_ref(input int a);
        int r0, r1, t0, t1, q, tmp;
        r0 = QI;
        r1 = a % QI;
        if (r1 == 0) return 0;
        t0 = 0;
        t1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        end
        if (t0 < 0) t0 += QI;
        return t0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_cnt   <= 0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_state <= 1;
                    m_cnt   <= 0;
                    m_inv   <= inv_ref(int'(in_a));
                    m_zero  <= ((int'(in_a) % QI) == 0) ? 1 : 0;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == int'(LATENCY)) m_state <= 2;
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", int'(in_ready), (m_state == 0) ? 1 : 0);
            chk("out_valid", int'(out_valid), (m_state == 2) ? 1 : 0);
            if (m_state == 2) begin
                chk("out_inv", int'(out_inv), m_inv);
                chk("out_zero", int'(out_zero), m_zero);
            end
        end
    end

    task automatic send(input int a);
        bit ok;
        ok = 0;
        in_a = 12'(a);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            chk("send_timeout", 0, 1);
        end
    endtask

    // Waits for a result, reports latency in edges after the accept edge, then takes it
    task automatic get(output int inv, output int zero, output int lat);
        inv = -1;
        zero = -1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i - 1;
                inv = int'(out_inv);
                zero = int'(out_zero);
                break;
            end
        end
        if (lat < 0) chk("get_timeout", 0, 1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_inv"}, int'(out_inv), 0);
        chk({tag, "_out_zero"}, int'(out_zero), 0);
    endtask

    int vec_a   [7] = '{2, 3, 2670, 2673, 0, 2671, 1};
    int vec_inv [7] = '{1336, 1781, 2670, 1336, 0, 0, 1};
    int vec_zero[7] = '{0, 0, 0, 0, 1, 1, 0};

    initial begin
        int inv, zero, lat, held, bad;

        rst = 1'b1;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        send(1);
        get(inv, zero, lat);
        chk("lat_first", lat, 18);
        chk("inv_1", inv, 1);
        chk("zero_1", zero, 0);

        foreach (vec_a[i]) begin
            send(vec_a[i]);
            get(inv, zero, lat);
            chk($sformatf("inv_a%0d", vec_a[i]), inv, vec_inv[i]);
            chk($sformatf("zero_a%0d", vec_a[i]), zero, vec_zero[i]);
            chk($sformatf("lat_a%0d", vec_a[i]), lat, 18);
        end

        send(4095);
        get(inv, zero, lat);
        chk("inv_4095_prod", (4095 % QI) * inv % QI, 1);

        // Back-pressure: hold result, offer a new operand that must wait
        out_ready = 1'b0;
        send(7);
        held = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                held = int'(out_inv);
                break;
            end
        end
        chk("hold_reached", (held >= 0) ? 1 : 0, 1);
        chk("inv_7_prod", 7 * held % QI, 1);
        in_a = 12'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_inv", int'(out_inv), held);
            chk("hold_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(5);
        get(inv, zero, lat);
        chk("inv_5", inv, 2137);
        chk("lat_5", lat, 18);

        // Reset mid-computation discards the operation
        send(1);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        send(1);
        get(inv, zero, lat);
        chk("rst_inv_1", inv, 1);
        chk("rst_lat", lat, 18);

        for (int a = 1; a < QI; a++) begin
            send(a);
            get(inv, zero, lat);
            chk($sformatf("prod_a%0d", a), a * inv % QI, 1);
        end

        // Standalone multiplier sweep with the clock stopped
        @(negedge clk);
        clk_en = 1'b0;
        for (int a = 0; a < QI; a++) begin
            bad = 0;
            for (int b = 0; b < QI; b++) begin
                mm_a = 12'(a);
                mm_b = 12'(b);
                #1;
                if (int'(mm_r) != (a * b) % QI) bad++;
            end
            chk($sformatf("modmul_row%0d", a), bad, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
